sig_debounce: RTL and testbench
===============================

SIG_DEBOUNCE -- requirements
Module: sig_debounce

Interface
REQ-001 Parameter STABLE_CNT, default 4: number of consecutive cycles the synchronized input must be stable before the output follows; legal range 2..255.
REQ-002 Parameter INIT_LVL, default 1'b0: level of dout and the starting idle state after reset.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: asynchronous, active-high reset.
REQ-005 Port din  input  1: raw asynchronous level, e.g. a pushbutton or external strobe.
REQ-006 Port dout  output  1: debounced, clk-synchronous level; registered.
REQ-007 Port dout_pe  output  1: one-cycle pulse on a debounced 0->1 transition; registered.
REQ-008 Port dout_ne  output  1: one-cycle pulse on a debounced 1->0 transition; registered.
REQ-009 Port busy  output  1: high while a candidate transition is being qualified.
REQ-010 Port glitch_cnt  output  8: saturating count of aborted candidate transitions; registered.

Function
REQ-011 din shall pass through a two-flop synchronizer; s_din is the second-flop output, and no other logic shall sample din.
REQ-012 The FSM shall have four one-hot states: IDLE_LO, WAIT_HI, IDLE_HI and WAIT_LO.
REQ-013 IDLE_LO: s_din=1 -> WAIT_HI with cnt<=0; otherwise hold.
REQ-014 WAIT_HI: s_din=0 -> IDLE_LO with cnt<=0 and glitch_cnt incremented; else if cnt==STABLE_CNT-1 -> IDLE_HI with dout<=1, dout_pe<=1 and cnt<=0; else cnt<=cnt+1.
REQ-015 IDLE_HI and WAIT_LO shall mirror REQ-013/014 with the polarities inverted; the qualified exit from WAIT_LO sets dout<=0 and dout_pe... dout_ne<=1.
REQ-016 dout_pe and dout_ne shall default to 0 every cycle, shall each be high for exactly one cycle per qualified transition, and shall never be high together.
REQ-017 Latency: with din held stable, dout changes on the (STABLE_CNT+3)th rising edge after the edge that first samples the new din level (2 synchronizer + 1 FSM entry + STABLE_CNT count), with the pulse in the same cycle.
REQ-018 A revert during WAIT_* at any count, including cnt==STABLE_CNT-1, shall take priority: abort, leave dout unchanged, and issue no pulse.
REQ-019 cnt shall be 8 bits unsigned and shall never exceed STABLE_CNT-1.
REQ-020 glitch_cnt shall increment by 1 per abort and saturate at 8'hFF; it shall not wrap.
REQ-021 busy = state is WAIT_HI or WAIT_LO (combinational decode of the state register).
REQ-022 An illegal state encoding shall recover to IDLE_LO if INIT_LVL=0, else IDLE_HI, with cnt<=0.

Reset
REQ-023 On rst=1, immediately and regardless of clk: both synchronizer flops <=INIT_LVL, state <=IDLE_LO (INIT_LVL=0) or IDLE_HI (INIT_LVL=1), cnt<=0, dout<=INIT_LVL, dout_pe<=0, dout_ne<=0, glitch_cnt<=0.
REQ-024 A reset asserted mid-qualification shall discard the pending transition and emit no pulse during or after reset.
REQ-025 After reset deassertion, with din==INIT_LVL, no pulse shall occur.

Structure
REQ-026 Package sig_debounce_pkg shall hold the one-hot state localparams (4'b0001..4'b1000), the counter width (8) and the glitch saturation value.
REQ-027 The synchronizer shall be the sub-module sync_2ff (clk, rst, d, q, reset value parameter), reused by other blocks.
REQ-028 sig_debounce shall contain the FSM, the qualification counter, the glitch counter and the registered outputs.

Verification (STABLE_CNT=4, INIT_LVL=0)
REQ-029 Reset, din=0 held for 20 cycles -> dout=0, no pulses, busy=0, glitch_cnt=0.
REQ-030 din 0->1 and held -> dout=1 and dout_pe=1 on edge 7 after first sample, dout_pe low on edge 8, busy high edges 3-6.
REQ-031 din high for 3 cycles, then 0 -> no dout change, no pulse, glitch_cnt=1.
REQ-032 From dout=1, din 1->0 held -> dout=0 with a single dout_ne pulse at edge 7; dout_pe stays 0.
REQ-033 300 glitches of 2 cycles each -> glitch_cnt=8'hFF, dout unchanged throughout.
REQ-034 din held high, rst pulsed at cnt=2 in WAIT_HI -> outputs return to reset values asynchronously; after release, dout rises after a full 7-edge qualification with a single dout_pe.

Source files
------------

// File: rtl/sig_debounce_pkg.sv
// rtl/sig_debounce_pkg.sv - shared constants and state encoding for the debouncer
package sig_debounce_pkg;

   localparam int         CNT_W      = 8;
   localparam logic [7:0] GLITCH_MAX = 8'hFF;

   localparam logic [3:0] ST_IDLE_LO = 4'b0001;
   localparam logic [3:0] ST_WAIT_HI = 4'b0010;
   localparam logic [3:0] ST_IDLE_HI = 4'b0100;
   localparam logic [3:0] ST_WAIT_LO = 4'b1000;

   typedef enum logic [3:0] {
      IDLE_LO = ST_IDLE_LO,
      WAIT_HI = ST_WAIT_HI,
      IDLE_HI = ST_IDLE_HI,
      WAIT_LO = ST_WAIT_LO
   } state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop level synchronizer with a configurable reset value
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/sig_debounce.sv
// rtl/sig_debounce.sv - debouncer: synchronizer, qualification FSM, edge pulses, glitch counter
import sig_debounce_pkg::*;

module sig_debounce #(
   parameter int   STABLE_CNT = 4,
   parameter logic INIT_LVL   = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       din,
   output logic       dout,
   output logic       dout_pe,
   output logic       dout_ne,
   output logic       busy,
   output logic [7:0] glitch_cnt
);

   localparam state_t            INIT_ST  = INIT_LVL ? IDLE_HI : IDLE_LO;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CNT - 1);

   logic             s_din;
   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             dout_next, pe_next, ne_next;
   logic [7:0]       glitch_next, glitch_inc;

   sync_2ff #(.RST_VAL(INIT_LVL)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (din),
      .q   (s_din)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= INIT_ST;
         cnt        <= '0;
         dout       <= INIT_LVL;
         dout_pe    <= 1'b0;
         dout_ne    <= 1'b0;
         glitch_cnt <= '0;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         dout       <= dout_next;
         dout_pe    <= pe_next;
         dout_ne    <= ne_next;
         glitch_cnt <= glitch_next;
      end
   end

   assign glitch_inc = (glitch_cnt == GLITCH_MAX) ? glitch_cnt : glitch_cnt + 8'd1;
   assign busy       = (state == WAIT_HI) || (state == WAIT_LO);

   // A revert is tested before the count so an abort on the last count still wins.
   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      dout_next   = dout;
      pe_next     = 1'b0;
      ne_next     = 1'b0;
      glitch_next = glitch_cnt;
      case (state)
         IDLE_LO: begin
            if (s_din) begin
               state_next = WAIT_HI;
               cnt_next   = '0;
            end
         end
         WAIT_HI: begin
            if (!s_din) begin
               state_next  = IDLE_LO;
               cnt_next    = '0;
               glitch_next = glitch_inc;
            end else if (cnt == CNT_LAST) begin
               state_next = IDLE_HI;
               dout_next  = 1'b1;
               pe_next    = 1'b1;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         IDLE_HI: begin
            if (!s_din) begin
               state_next = WAIT_LO;
               cnt_next   = '0;
            end
         end
         WAIT_LO: begin
            if (s_din) begin
               state_next  = IDLE_HI;
               cnt_next    = '0;
               glitch_next = glitch_inc;
            end else if (cnt == CNT_LAST) begin
               state_next = IDLE_LO;
               dout_next  = 1'b0;
               ne_next    = 1'b1;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         default: begin
            state_next = INIT_ST;
            cnt_next   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_sig_debounce.sv
// tb/tb_sig_debounce.sv - randomized bench for sig_debounce against a run-length reference model
module tb_sig_debounce;

   localparam int STABLE = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       din;
   logic       dout, dout_pe, dout_ne, busy;
   logic [7:0] glitch_cnt;

   int checks = 0;
   int errors = 0;

   // Reference: s_din is din delayed two edges; dout flips once s_din has
   // disagreed with it on STABLE+1 consecutive edges, any agreement in between
   // is an abort.
   logic m_s1, m_s2, m_dout, m_pe, m_ne;
   int   m_run, m_glitch;

   sig_debounce #(.STABLE_CNT(STABLE), .INIT_LVL(1'b0)) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .dout       (dout),
      .dout_pe    (dout_pe),
      .dout_ne    (dout_ne),
      .busy       (busy),
      .glitch_cnt (glitch_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_s1 = 1'b0; m_s2 = 1'b0; m_dout = 1'b0; m_pe = 1'b0; m_ne = 1'b0;
         m_run = 0; m_glitch = 0;
      end else begin
         m_pe = 1'b0;
         m_ne = 1'b0;
         if (m_s2 != m_dout) begin
            m_run++;
            if (m_run == STABLE + 1) begin
               m_dout = ~m_dout;
               m_pe   = m_dout;
               m_ne   = ~m_dout;
               m_run  = 0;
            end
         end else begin
            if (m_run > 0 && m_glitch < 255) m_glitch++;
            m_run = 0;
         end
         m_s2 = m_s1;
         m_s1 = din;
      end
   end

   always @(negedge clk) begin
      logic [11:0] act, exp_v;
      act   = {dout, dout_pe, dout_ne, busy, glitch_cnt};
      exp_v = {m_dout, m_pe, m_ne, (m_run > 0), 8'(m_glitch)};
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL model t=%0t {dout,pe,ne,busy,glitch} actual=%h required=%h", $time, act, exp_v);
      end
   end

   task automatic check(input string name, input logic [7:0] actual, input logic [7:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, actual, required);
      end
   endtask

   initial begin
      rst = 1'b1;
      din = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // reset state, din held low
      repeat (20) @(negedge clk);
      check("idle_dout", {7'd0, dout}, 8'd0);
      check("idle_busy", {7'd0, busy}, 8'd0);
      check("idle_pulses", {6'd0, dout_pe, dout_ne}, 8'd0);
      check("idle_glitch", glitch_cnt, 8'd0);

      // rising qualification, edge 1 is the first sample of the new level
      din = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         @(posedge clk); #1;
         if (e == 2) check("rise_busy_e2", {7'd0, busy}, 8'd0);
         if (e == 3) check("rise_busy_e3", {7'd0, busy}, 8'd1);
         if (e == 6) check("rise_e6", {5'd0, dout, dout_pe, busy}, 8'b001);
         if (e == 7) check("rise_e7", {5'd0, dout, dout_pe, busy}, 8'b110);
         if (e == 8) check("rise_e8", {6'd0, dout, dout_pe}, 8'b10);
      end
      @(negedge clk);

      // falling qualification
      din = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         @(posedge clk); #1;
         if (e == 6) check("fall_e6", {5'd0, dout, dout_ne, dout_pe}, 8'b100);
         if (e == 7) check("fall_e7", {5'd0, dout, dout_ne, dout_pe}, 8'b010);
         if (e == 8) check("fall_e8", {6'd0, dout, dout_ne}, 8'b00);
      end
      @(negedge clk);

      // three-cycle glitch
      din = 1'b1;
      repeat (3) @(negedge clk);
      din = 1'b0;
      repeat (10) @(negedge clk);
      check("glitch3_cnt", glitch_cnt, 8'd1);
      check("glitch3_dout", {7'd0, dout}, 8'd0);

      // reset during WAIT_HI at cnt==2
      din = 1'b1;
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_glitch", glitch_cnt, 8'd0);
      check("async_rst_busy", {7'd0, busy}, 8'd0);
      check("async_rst_out", {5'd0, dout, dout_pe, dout_ne}, 8'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         @(posedge clk); #1;
         if (e == 6) check("rst_requal_e6", {6'd0, dout, dout_pe}, 8'b00);
         if (e == 7) check("rst_requal_e7", {6'd0, dout, dout_pe}, 8'b11);
         if (e == 8) check("rst_requal_e8", {6'd0, dout, dout_pe}, 8'b10);
      end
      @(negedge clk);

      // saturation: 300 two-cycle low glitches from dout=1
      for (int g = 0; g < 300; g++) begin
         din = 1'b0;
         repeat (2) @(negedge clk);
         din = 1'b1;
         repeat (4) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      check("sat_glitch", glitch_cnt, 8'hFF);
      check("sat_dout", {7'd0, dout}, 8'd1);

      // random levels with random hold times and occasional resets
      for (int r = 0; r < 600; r++) begin
         din = 1'($urandom);
         if ($urandom_range(0, 40) == 0) begin
            #2 rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
         repeat ($urandom_range(1, 8)) @(negedge clk);
      end
      din = 1'b0;
      repeat (12) @(negedge clk);
      check("final_dout", {7'd0, dout}, 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
